// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state type and shifter modes for seq_alu.
// SEQ_ALU_DIV_EN decides whether opcode 0011 is iterative or illegal.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1011;

  localparam logic [2:0] SH_SRL = 3'd0;
  localparam logic [2:0] SH_SRA = 3'd1;
  localparam logic [2:0] SH_SLL = 3'd2;
  localparam logic [2:0] SH_ROR = 3'd3;
  localparam logic [2:0] SH_ROL = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return op == OP_MUL;
`endif
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter / rotator: srl, sra, sll, ror, rol by 0..WIDTH-1.
// Latency 0; no flow control.
// Purely combinational, no backpressure.
module alu_shifter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result
);

  localparam logic [SHW:0] WFULL = (SHW+1)'(WIDTH);

  logic [SHW:0]       back_amt;
  logic [WIDTH-1:0]   ror_val;
  logic [WIDTH-1:0]   rol_val;

  // A shift of WIDTH yields zero, so amount 0 rotates cleanly to value itself.
  assign back_amt = WFULL - {1'b0, amount};
  assign ror_val  = (value >> amount) | (value << back_amt);
  assign rol_val  = (value << amount) | (value >> back_amt);

  always_comb begin
    case (mode)
      SH_SRL:  result = value >> amount;
      SH_SRA:  result = $unsigned($signed(value) >>> amount);
      SH_SLL:  result = value << amount;
      SH_ROR:  result = ror_val;
      SH_ROL:  result = rol_val;
      default: result = value;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops plus Booth multiply and (SEQ_ALU_DIV_EN) restoring divide.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for mul/div after accept.
// start is ignored while busy; a new start may be accepted in the cycle done is high.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             err
);

  localparam logic [SHW-1:0] LAST = '1;

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [WIDTH:0]   acc, acc_nxt;
  logic [WIDTH-1:0] qreg, qreg_nxt;
  logic [WIDTH-1:0] mreg, mreg_nxt;
  logic             q1, q1_nxt;
  logic             done_nxt, err_nxt;
  logic [WIDTH-1:0] lo_nxt, hi_nxt;

  logic [WIDTH:0]   add_full, sub_full;
  logic [2:0]       sh_mode;
  logic [WIDTH-1:0] sh_result;
  logic             go_iter;

  assign busy     = (state != IDLE);
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign go_iter  = is_iterative(op) && !((op == OP_DIV) && (b == '0));

  always_comb begin
    case (op)
      OP_SRA:  sh_mode = SH_SRA;
      OP_SLL:  sh_mode = SH_SLL;
      OP_ROR:  sh_mode = SH_ROR;
      OP_ROL:  sh_mode = SH_ROL;
      default: sh_mode = SH_SRL;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .value  (a),
    .amount (b[SHW-1:0]),
    .mode   (sh_mode),
    .result (sh_result)
  );

  // Booth step: acc is one bit wider so subtracting the most negative multiplicand cannot overflow.
  logic [WIDTH:0]   m_ext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_q;

  always_comb begin
    m_ext = {mreg[WIDTH-1], mreg};
    case ({qreg[0], q1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], qreg[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // Restoring step: acc holds the partial remainder, qreg shifts dividend out and quotient in.
  logic [WIDTH:0] div_shift, div_diff, div_rem;
  logic           div_ok;

  always_comb begin
    div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mreg};
    div_ok    = ~div_diff[WIDTH];
    div_rem   = div_ok ? div_diff : div_shift;
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    qreg_nxt  = qreg;
    mreg_nxt  = mreg;
    q1_nxt    = q1;
    done_nxt  = 1'b0;
    lo_nxt    = lo;
    hi_nxt    = hi;
    err_nxt   = err;

    case (state)
      IDLE: begin
        if (start) begin
          if (go_iter) begin
            cnt_nxt = '0;
            acc_nxt = '0;
            q1_nxt  = 1'b0;
            if (op == OP_MUL) begin
              state_nxt = MUL;
              mreg_nxt  = a;
              qreg_nxt  = b;
            end
`ifdef SEQ_ALU_DIV_EN
            else begin
              state_nxt = DIV;
              mreg_nxt  = b;
              qreg_nxt  = a;
            end
`endif
          end else begin
            done_nxt = 1'b1;
            err_nxt  = 1'b0;
            lo_nxt   = '0;
            hi_nxt   = '0;
            case (op)
              OP_ADD: begin
                lo_nxt = add_full[WIDTH-1:0];
                hi_nxt = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
              end
              OP_SUB: begin
                lo_nxt = sub_full[WIDTH-1:0];
                hi_nxt = {{(WIDTH-1){1'b0}}, sub_full[WIDTH]};
              end
`ifdef SEQ_ALU_DIV_EN
              OP_DIV: begin
                lo_nxt  = '1;
                hi_nxt  = a;
                err_nxt = 1'b1;
              end
`endif
              OP_AND: lo_nxt = a & b;
              OP_OR:  lo_nxt = a | b;
              OP_SRL, OP_SRA, OP_SLL, OP_ROR, OP_ROL: lo_nxt = sh_result;
              default: err_nxt = 1'b1;
            endcase
          end
        end
      end

      MUL: begin
        acc_nxt  = booth_acc;
        qreg_nxt = booth_q;
        q1_nxt   = qreg[0];
        cnt_nxt  = cnt + SHW'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          lo_nxt    = booth_q;
          hi_nxt    = booth_acc[WIDTH-1:0];
          err_nxt   = 1'b0;
        end
      end

`ifdef SEQ_ALU_DIV_EN
      DIV: begin
        acc_nxt  = div_rem;
        qreg_nxt = {qreg[WIDTH-2:0], div_ok};
        cnt_nxt  = cnt + SHW'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          lo_nxt    = {qreg[WIDTH-2:0], div_ok};
          hi_nxt    = div_rem[WIDTH-1:0];
          err_nxt   = 1'b0;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      qreg <= '0;
      mreg <= '0;
      q1   <= 1'b0;
      done <= 1'b0;
      lo   <= '0;
      hi   <= '0;
      err  <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      acc  <= acc_nxt;
      qreg <= qreg_nxt;
      mreg <= mreg_nxt;
      q1   <= q1_nxt;
      done <= done_nxt;
      lo   <= lo_nxt;
      hi   <= hi_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: issued ops push expected results, a monitor pops on done.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, err;
  logic [W-1:0] lo, hi;

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lo    (lo),
    .hi    (hi),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         err;
    int           lat;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_lo = -1;
  int   busy_hi = -2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model from the opcode table using plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    int           s;
    longint       sum;
    longint       prod;
    logic [63:0]  pv;
    logic [W-1:0] r;
    e.lo = '0; e.hi = '0; e.err = 1'b0; e.lat = 1; e.cyc = 0;
    s = int'(y % W);
    case (o)
      4'b0001: begin
        sum  = longint'(x) + longint'(y);
        e.lo = W'(sum);
        e.hi = W'(sum >> 32);
      end
      4'b0010: begin
        e.lo = x - y;
        e.hi = (x < y) ? 32'd1 : 32'd0;
      end
      4'b0011: begin
`ifdef SEQ_ALU_DIV_EN
        if (y == 0) begin
          e.err = 1'b1; e.lo = '1; e.hi = x;
        end else begin
          e.lo = x / y; e.hi = x % y; e.lat = W + 1;
        end
`else
        e.err = 1'b1;
`endif
      end
      4'b0100: begin
        prod = longint'($signed(x)) * longint'($signed(y));
        pv   = prod;
        e.lo = pv[31:0];
        e.hi = pv[63:32];
        e.lat = W + 1;
      end
      4'b0101: e.lo = x & y;
      4'b0110: e.lo = x | y;
      4'b0111: e.lo = x >> s;
      4'b1000: e.lo = $unsigned($signed(x) >>> s);
      4'b1001: e.lo = x << s;
      4'b1010: begin
        r = x;
        for (int i = 0; i < s; i++) r = {r[0], r[W-1:1]};
        e.lo = r;
      end
      4'b1011: begin
        r = x;
        for (int i = 0; i < s; i++) r = {r[W-2:0], r[W-1]};
        e.lo = r;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("issue_idle", busy, 0);
    e = model(o, x, y);
    e.cyc = cyc + e.lat;
    if (e.lat > 1) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + W;
    end
    q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_drained"}, q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_lo"}, lo, 0);
    check({tag, "_hi"}, hi, 0);
    check({tag, "_err"}, err, 0);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          mon_e = q.pop_front();
          check("lo", lo, mon_e.lo);
          check("hi", hi, mon_e.hi);
          check("err", err, mon_e.err);
          check("done_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] rx, ry;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    issue(OP_SUB, 32'd5, 32'd7);
    issue(OP_MUL, 32'hFFFF_FFFD, 32'd7);
    issue(OP_MUL, 32'h8000_0000, 32'h8000_0000);
    issue(OP_DIV, 32'd100, 32'd7);
    issue(OP_DIV, 32'd100, 32'd0);
    issue(OP_ROR, 32'h8000_0001, 32'd4);
    issue(OP_SRA, 32'h8000_0000, 32'd31);
    issue(OP_SLL, 32'd1, 32'd0);
    issue(4'b1111, 32'h1234, 32'h5678);
    issue(4'b0000, 32'h1, 32'h1);
    issue(OP_ROL, 32'h8000_0001, 32'd1);
    drain("directed");

    // Start pulsed mid-multiply must be ignored without disturbing the product.
    issue(OP_MUL, 32'd1234, 32'hFFFF_FFFB);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    drain("ignore");

    // Asynchronous reset in the middle of a multiply.
    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    q.delete();
    busy_lo = -1;
    busy_hi = -2;
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 32'd10, 32'd20);
    drain("post_reset");

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = $urandom;
      if (ro == OP_DIV) begin
        if ($urandom_range(0, 3) == 0) ry = '0;
        else if ($urandom_range(0, 1) == 0) ry = ry >> $urandom_range(0, 31);
      end
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      issue(ro, rx, ry);
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU that succeeds the combinational datapath ALU. It keeps the same 4-bit opcode map and adds several things the older block lacks: a clocked start/done handshake, variable shift and rotate amounts, add/sub carry-out, and iterative Booth multiply and restoring divide at one bit per cycle. It sits between the register-file read ports and the Z/HI/LO write-back path of the datapath.

## Interface
- WIDTH, 32, operand width in bits; must be a power of two and at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on a cycle where busy=0.
- op  in  4  opcode, sampled with start.
- a  in  WIDTH  operand A / dividend / multiplicand, sampled with start.
- b  in  WIDTH  operand B / divisor / multiplier; b[SHW-1:0] is the shift amount.
- busy  out  1  high while an iterative operation runs.
- done  out  1  single-cycle pulse when lo, hi and err are valid.
- lo  out  WIDTH  primary result / low product / quotient.
- hi  out  WIDTH  secondary result / high product / remainder.
- err  out  1  illegal opcode or divide by zero; valid with done.

## Operation
- Opcodes and results:
  - 0001 add: lo=a+b, hi={0,carry}.
  - 0010 sub: lo=a-b, plain two's complement; hi={0,borrow}.
  - 0011 div: unsigned; lo=quotient, hi=remainder.
  - 0100 mul: signed; {hi,lo} = a*b, full 2·WIDTH product.
  - 0101 and, 0110 or: hi=0.
  - 0111 logical right shift, 1000 arithmetic right shift, 1001 left shift, 1010 rotate right, 1011 rotate left: amount = b[SHW-1:0] (0..WIDTH-1); hi=0.
  - Any other opcode: lo=0, hi=0, err=1.
- State machine states: IDLE, MUL, DIV.
  - IDLE + start + single-cycle op: register the result and pulse done; remain in IDLE.
  - IDLE + start + 0100: go to MUL. Radix-2 Booth; the iteration counter runs WIDTH cycles, then returns to IDLE with done.
  - IDLE + start + 0011 with b≠0: go to DIV. Restoring shift-subtract; WIDTH cycles, then IDLE with done.
  - 0011 with b=0: no iteration. Done the next cycle with err=1, lo=all ones, hi=a.
- start is ignored while busy=1. Operands are captured internally at accept, so a and b may change freely afterwards.
- lo, hi and err hold their values until the next done.
- Reset (asynchronous at any time, including mid-iteration): abort the operation and return to IDLE. busy=0, done=0, lo=0, hi=0, err=0.

## Timing
- Start accepted at edge N.
  - Single-cycle ops, illegal ops, divide by zero: done=1 after edge N+1.
  - mul/div: busy=1 from after edge N+1 through edge N+WIDTH; done=1 after edge N+WIDTH+1, with busy=0 in the same cycle.
- A new start may be accepted in the same cycle done is high, giving back-to-back throughput.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SEQ_ALU_DIV_EN defined: the divider datapath and the DIV state are compiled in.
- SEQ_ALU_DIV_EN undefined: opcode 0011 behaves as an illegal opcode (done after N+1, lo=hi=0, err=1), and the DIV state and its registers are absent.

## Structure
- seq_alu_pkg holds:
  - the opcode localparams (OP_ADD … OP_ROL),
  - the state enum (IDLE, MUL, DIV),
  - a function returning whether an opcode is iterative.
- Sub-module alu_shifter: combinational barrel shifter/rotator. Parameter WIDTH; inputs value, amount and a 3-bit mode; output result. It is instantiated once.
- The add/sub carry chain, Booth accumulator, divider and control FSM stay in seq_alu.

## Test plan
Values are for WIDTH=32.
- add a=0xFFFFFFFF, b=1 -> lo=0, hi=1, err=0, done one cycle after accept; sub a=5, b=7 -> lo=0xFFFFFFFE, hi=1.
- mul a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 32 cycles, done at accept+33; also a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- div a=100, b=7 -> lo=14, hi=2 at accept+33; div a=100, b=0 -> err=1, lo=0xFFFFFFFF, hi=100 at accept+1.
- ror a=0x80000001, b=4 -> lo=0x18000000; asr a=0x80000000, b=31 -> lo=0xFFFFFFFF; shl a=1, b=0 -> lo=1; op=1111 -> lo=hi=0, err=1.
- Pulse start with add during cycle 5 of a mul -> ignored, and the mul result is unaffected; assert rst_n low at mul cycle 10 -> busy/done/lo/hi/err all 0 immediately, and a following add completes normally.
- Build without SEQ_ALU_DIV_EN: div a=100, b=7 -> err=1, lo=hi=0 at accept+1.
